// File: rtl/fetch_stall_pipe.sv
// Fetch side of the load-use hazard interface: PC, two-slot IF/ID bundle register
// and ID/EX control register, with stall/bubble handling and branch redirects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// BOOT     | first cycle after reset; PC holds, ID/EX gets a bubble
// RUN      | normal fetch, no stall requested last edge
// STALL    | at least one hazard enable was active last edge
// REDIRECT | one cycle after a taken branch; fetches the target bundle
module fetch_stall_pipe #(
    parameter int              PC_W      = 8,
    parameter int              INSTR_W   = 16,
    parameter int              CTRL_W    = 12,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_STALL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 if_id_write,
    input  logic                 id_ex_control_value,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_target,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [2*INSTR_W-1:0] imem_bundle,
    output logic [INSTR_W-1:0]   if_id_instr0,
    output logic [INSTR_W-1:0]   if_id_instr1,
    output logic [PC_W-1:0]      if_id_pc,
    output logic                 if_id_valid,
    input  logic [CTRL_W-1:0]    id_ctrl_in,
    output logic [CTRL_W-1:0]    id_ex_ctrl,
    output logic                 id_ex_valid,
    output logic [15:0]          stall_count,
    output logic                 stall_timeout,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(MAX_STALL);

    state_t           state_q;
    logic [PC_W-1:0]  pc_q;
    // Stall-run timer counts down from MAX_STALL; a stalled edge at zero is run MAX_STALL+1.
    logic [RUN_W-1:0] run_left;
    logic             stall_req;

    assign stall_req = !pc_write || !if_id_write || id_ex_control_value;
    assign imem_addr = pc_q;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            if_id_instr0  <= '0;
            if_id_instr1  <= '0;
            if_id_pc      <= '0;
            if_id_valid   <= 1'b0;
            id_ex_ctrl    <= '0;
            id_ex_valid   <= 1'b0;
            stall_count   <= '0;
            stall_timeout <= 1'b0;
            run_left      <= RUN_LOAD;
            state_q       <= BOOT;
        end else if (state_q == BOOT) begin
            if_id_valid <= 1'b0;
            id_ex_ctrl  <= '0;
            id_ex_valid <= 1'b0;
            state_q     <= RUN;
        end else if (branch_taken) begin
            pc_q         <= branch_target;
            if_id_instr0 <= '0;
            if_id_instr1 <= '0;
            if_id_pc     <= '0;
            if_id_valid  <= 1'b0;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
            run_left     <= RUN_LOAD;
            state_q      <= REDIRECT;
        end else if (state_q == REDIRECT) begin
            // ID holds a NOP here, so any hazard request is spurious and ignored.
            pc_q         <= pc_q + 1'b1;
            if_id_instr0 <= imem_bundle[INSTR_W-1:0];
            if_id_instr1 <= imem_bundle[2*INSTR_W-1:INSTR_W];
            if_id_pc     <= pc_q;
            if_id_valid  <= 1'b1;
            id_ex_ctrl   <= '0;
            id_ex_valid  <= 1'b0;
            state_q      <= RUN;
        end else begin
            if (pc_write) begin
                pc_q <= pc_q + 1'b1;
            end
            if (if_id_write) begin
                if_id_instr0 <= imem_bundle[INSTR_W-1:0];
                if_id_instr1 <= imem_bundle[2*INSTR_W-1:INSTR_W];
                if_id_pc     <= pc_q;
                if_id_valid  <= 1'b1;
            end
            if (id_ex_control_value) begin
                id_ex_ctrl  <= '0;
                id_ex_valid <= 1'b0;
            end else begin
                id_ex_ctrl  <= id_ctrl_in;
                id_ex_valid <= if_id_valid;
            end
            if (stall_req) begin
                state_q <= STALL;
                if (stall_count != 16'hFFFF) begin
                    stall_count <= stall_count + 16'd1;
                end
                if (run_left == '0) begin
                    stall_timeout <= 1'b1;
                end else begin
                    run_left <= run_left - 1'b1;
                end
            end else begin
                state_q  <= RUN;
                run_left <= RUN_LOAD;
            end
        end
    end

endmodule

// File: doc/fetch_stall_pipe.md
Name: fetch_stall_pipe

Overview:
- Consumer end of the load-use hazard interface: owns the PC register, the two-slot IF/ID bundle register and the ID/EX control register.
- Applies the stall and bubble requests from hazard detection, plus branch redirects from EX.
- Sits between instruction memory and decode in the two-issue VLIW pipeline. Slot0 carries the ALU/shift instruction; slot1 carries the load/store instruction.

Parameters:
- PC_W, 8, PC width in bundles; PC increments by 1 per bundle.
- INSTR_W, 16, width of one slot instruction.
- CTRL_W, 12, width of the decoded ID/EX control word.
- RESET_PC, 0, PC value loaded at reset.
- MAX_STALL, 8, consecutive stall cycles before stall_timeout is flagged.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active-low.
- pc_write  in  1  1 = PC may advance; 0 = hold PC.
- if_id_write  in  1  1 = IF/ID may capture; 0 = hold IF/ID.
- id_ex_control_value  in  1  1 = inject bubble into ID/EX.
- branch_taken  in  1  redirect request from EX.
- branch_target  in  PC_W  redirect bundle address.
- imem_addr  out  PC_W  fetch address; combinationally equal to the PC register.
- imem_bundle  in  2*INSTR_W  fetched bundle; [INSTR_W-1:0] = slot0.
- if_id_instr0  out  INSTR_W  registered slot0 instruction.
- if_id_instr1  out  INSTR_W  registered slot1 instruction.
- if_id_pc  out  PC_W  PC of the bundle held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real bundle.
- id_ctrl_in  in  CTRL_W  decoder control output for the IF/ID bundle.
- id_ex_ctrl  out  CTRL_W  registered control word.
- id_ex_valid  out  1  ID/EX holds a real instruction.
- stall_count  out  16  saturating total of stalled cycles.
- stall_timeout  out  1  sticky flag: stall run exceeded MAX_STALL.
- state  out  2  0=BOOT, 1=RUN, 2=STALL, 3=REDIRECT.

Behaviour:
- Reset (reset==0 at a clk edge), applied regardless of state:
  - pc=RESET_PC.
  - if_id_instr0/1=0, if_id_pc=0, if_id_valid=0.
  - id_ex_ctrl=0, id_ex_valid=0.
  - stall_count=0, stall_timeout=0, consecutive-stall counter=0, state=BOOT.
  - Reset mid-stall or mid-redirect discards everything.
- BOOT: lasts exactly one cycle. PC holds, IF/ID stays invalid, ID/EX gets a bubble. Next state is RUN. Hazard inputs and branch_taken are ignored.
- Priority in RUN, STALL and REDIRECT: branch_taken > stall/bubble > normal advance.
- branch_taken=1:
  - pc<=branch_target.
  - IF/ID<=0 with valid 0.
  - id_ex_ctrl<=0, id_ex_valid<=0.
  - Consecutive-stall counter<=0, state<=REDIRECT.
  - This overrides any simultaneous pc_write=0 / if_id_write=0 / id_ex_control_value=1.
- REDIRECT:
  - Lasts one cycle. The hazard inputs are ignored because ID holds a NOP and any stall request is spurious.
  - pc<=pc+1; IF/ID captures imem_bundle with if_id_pc<=pc and valid 1.
  - ID/EX gets a bubble; next state is RUN.
  - A branch_taken asserted in REDIRECT re-enters REDIRECT with the new target.
- Normal update (RUN or STALL, no branch). Each enable is honoured independently, so mismatched combinations are legal:
  - pc_write=1 → pc<=pc+1, wrapping modulo 2^PC_W (all-ones→0). Otherwise pc holds.
  - if_id_write=1 → IF/ID<=imem_bundle, if_id_pc<=pc, if_id_valid<=1. Otherwise all IF/ID fields hold.
  - id_ex_control_value=1 → id_ex_ctrl<=0, id_ex_valid<=0. Otherwise id_ex_ctrl<=id_ctrl_in, id_ex_valid<=if_id_valid.
- Stall state machine (no branch):
  - stall_req = !pc_write | !if_id_write | id_ex_control_value.
  - RUN→STALL when stall_req=1; STALL→RUN when stall_req=0; otherwise the state holds.
- Counters (no branch, not BOOT/REDIRECT):
  - While stall_req=1, stall_count increments each cycle, saturating at 0xFFFF.
  - The consecutive-stall counter increments while stall_req=1 and clears when stall_req=0.
  - When the consecutive count reaches MAX_STALL+1, stall_timeout<=1. It stays set until reset.
- All outputs are registered except imem_addr. The hazard-to-effect latency is one edge.

Test Plan:
- Reset: hold reset=0 for 2 cycles with RESET_PC=0x10, then release → imem_addr=0x10, state BOOT for 1 cycle then RUN; first valid IF/ID holds bundle@0x10 with if_id_pc=0x10.
- Load-use stall: in RUN, pulse pc_write=0, if_id_write=0, id_ex_control_value=1 for 1 cycle →
  - PC and IF/ID unchanged; id_ex_ctrl=0, id_ex_valid=0.
  - state STALL then RUN; stall_count=1.
  - The next bundle is fetched exactly once, with no duplication and no loss.
- Branch during stall: stall inputs held active with branch_taken=1, branch_target=0x40 →
  - pc=0x40, if_id_valid=0, id_ex_valid=0, state REDIRECT.
  - Next cycle IF/ID=bundle@0x40 even though the stall inputs are still asserted.
- PC wrap: PC_W=8 with pc=0xFF and no stall → pc=0x00, and if_id_pc=0xFF for the captured bundle.
- Timeout and saturation:
  - Hold stall_req for MAX_STALL+1=9 cycles → stall_timeout rises on the 9th stalled edge and stays 1 after the stall ends.
  - Preload stall_count near 0xFFFF via a long stall → stall_count stays at 0xFFFF.
- Independent enables: pc_write=0 with if_id_write=1 for 2 cycles → IF/ID recaptures the same bundle each cycle, if_id_pc constant, state STALL.
